pwm_sched: RTL

- Sequencer for the shared Kyber modular multiplier (12-bit operands, result mod q=3329, fixed latency MULT_LAT).
- On a start pulse, streams N coefficient pairs from two operand RAMs into the multiplier and writes the N reduced products to a result RAM.
- Two modes: pointwise (C[i] = A[i]*B[i] mod q) and scalar (C[i] = A[i]*K mod q, K latched at start).
- Sits between the polynomial RAM bank and the multiplier instance in the NTT/basemul datapath.

---
 rtl/pwm_sched_if.sv | 31 +++
 rtl/pwm_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/pwm_sched_if.sv
// Signal bundle between the coefficient-multiply sequencer and its surroundings:
// job control, operand RAM read port, multiplier operands/result and result RAM write port.
interface pwm_sched_if #(
    parameter int AW = 8
);
    logic          start;
    logic          mode;
    logic [11:0]   k_const;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [11:0]   a_rdata;
    logic [11:0]   b_rdata;
    logic [11:0]   mul_in1;
    logic [11:0]   mul_in2;
    logic [11:0]   mul_res;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;

    modport master (
        input  start, mode, k_const, a_rdata, b_rdata, mul_res,
        output busy, done, rd_en, rd_addr, mul_in1, mul_in2, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, mode, k_const, a_rdata, b_rdata, mul_res,
        input  busy, done, rd_en, rd_addr, mul_in1, mul_in2, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pwm_sched.sv
// Streams N coefficient pairs from the operand RAMs through the shared modular
// multiplier and writes the N products to the result RAM (pointwise or scalar mode).
module pwm_sched #(
    parameter int N        = 256,
    parameter int AW       = 8,
    parameter int RD_LAT   = 1,
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    pwm_sched_if.master bus
);
    localparam int D = RD_LAT + MULT_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          r_mode;
    logic [11:0]   r_k;
    logic [AW-1:0] r_rdAddr;
    logic [D-1:0]  r_vPipe;
    logic [AW-1:0] r_aPipe [D];

    logic          w_rdEn;
    logic          w_load;
    logic          w_opValid;
    logic          w_wrEn;
    logic [AW-1:0] w_wrAddr;

    assign w_opValid = r_vPipe[RD_LAT-1];
    assign w_wrEn    = r_vPipe[D-1];
    assign w_wrAddr  = r_aPipe[D-1];

    // A start in the done cycle chains straight into the next job.
    always_comb begin
        w_nextState = r_state;
        w_rdEn      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = ISSUE;
                end
            end
            ISSUE: begin
                w_rdEn = 1'b1;
                if (r_rdAddr == AW'(N - 1)) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_wrEn && (w_wrAddr == AW'(N - 1))) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_nextState = ISSUE;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= 1'b0;
            r_k      <= '0;
            r_rdAddr <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_load) begin
                r_mode <= bus.mode;
                r_k    <= bus.k_const;
            end
            if (w_rdEn) begin
                r_rdAddr <= (r_rdAddr == AW'(N - 1)) ? '0 : r_rdAddr + 1'b1;
            end
        end
    end

    // Address stages only advance behind a valid bit, so the tail keeps the last written address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vPipe <= '0;
            for (int k = 0; k < D; k++) begin
                r_aPipe[k] <= '0;
            end
        end else begin
            r_vPipe[0] <= w_rdEn;
            if (w_rdEn) begin
                r_aPipe[0] <= r_rdAddr;
            end
            for (int k = 1; k < D; k++) begin
                r_vPipe[k] <= r_vPipe[k-1];
                if (r_vPipe[k-1]) begin
                    r_aPipe[k] <= r_aPipe[k-1];
                end
            end
        end
    end

    assign bus.busy    = (r_state == ISSUE) || (r_state == DRAIN);
    assign bus.done    = (r_state == FIN);
    assign bus.rd_en   = w_rdEn;
    assign bus.rd_addr = r_rdAddr;
    assign bus.mul_in1 = w_opValid ? bus.a_rdata : 12'd0;
    assign bus.mul_in2 = w_opValid ? (r_mode ? r_k : bus.b_rdata) : 12'd0;
    assign bus.wr_en   = w_wrEn;
    assign bus.wr_addr = w_wrAddr;
    assign bus.wr_data = w_wrEn ? bus.mul_res : 12'd0;
endmodule
